// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master.
// funct3 codes, mem_we encodings, FSM states and request decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_W    = 2'b01;
  localparam logic [1:0] WE_H    = 2'b10;
  localparam logic [1:0] WE_B    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_STORE_BYTES,
    S_LOAD,
    S_LOAD_HI,
    S_RESP
  } state_e;

  // Access size in bytes from funct3[1:0].
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    logic [2:0] s;
    case (f3[1:0])
      2'b00:   s = 3'd1;
      2'b01:   s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

  // Stores only allow B/H/W; loads also allow BU/HU.
  function automatic logic f3_legal(input logic st,
                                    input logic [2:0] f3);
    logic ok;
    if (st)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // Write strobe encoding for a single aligned store.
  function automatic logic [1:0] f3_we(input logic [2:0] f3);
    logic [1:0] we;
    case (f3[1:0])
      2'b00:   we = WE_B;
      2'b01:   we = WE_H;
      default: we = WE_W;
    endcase
    return we;
  endfunction

  // A load needs two word reads when it crosses a word boundary.
  function automatic logic ld_split(input logic [1:0] off,
                                    input logic [2:0] f3);
    logic [2:0] ends;
    ends = {1'b0, off} + f3_size(f3);
    return ends > 3'd4;
  endfunction

  // Stores must be naturally aligned to use a single access.
  function automatic logic st_mis(input logic [1:0] off,
                                  input logic [2:0] f3);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_master_extract.sv
// Load data extraction from a two-word window.
// Shifts {hi,lo} by the byte offset and sign/zero extends.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] hi_buf_i,
  input  logic [31:0] lo_buf_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [63:0] win;

  assign win = {hi_buf_i, lo_buf_i} >> {off_i, 3'b000};

  // Pick the low bytes of the window and extend them.
  always_comb begin
    rdata_o = win[31:0];
    unique case (funct3_i)
      F3_B:    rdata_o = {{24{win[7]}}, win[7:0]};
      F3_H:    rdata_o = {{16{win[15]}}, win[15:0]};
      F3_BU:   rdata_o = {24'b0, win[7:0]};
      F3_HU:   rdata_o = {16'b0, win[15:0]};
      default: rdata_o = win[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator driving the data-memory port.
// Splits misaligned loads into two reads and stores into byte writes.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter bit ENABLE_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  k_q;
  logic [31:0] lo_buf_q;
  logic [31:0] hi_buf_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [1:0]  mem_we_q;
  logic [31:0] mem_a_q;
  logic [31:0] mem_wd_q;

  logic        req_ok_d;
  logic        req_mis_d;
  logic        reject_d;
  logic [1:0]  k_d;
  logic        last_d;
  logic [31:0] wsh_d;
  logic [31:0] ext_lo_d;
  logic [31:0] ext_hi_d;
  logic [31:0] ext_d;

  // Decode the incoming request and the byte-store step.
  always_comb begin
    req_ok_d  = f3_legal(req_store, req_funct3);
    req_mis_d = req_store ? st_mis(req_addr[1:0], req_funct3)
                          : ld_split(req_addr[1:0], req_funct3);
    reject_d  = !req_ok_d || (req_mis_d && !ENABLE_MISALIGNED);
    k_d       = k_q + 2'd1;
    last_d    = ({1'b0, k_q} == f3_size(f3_q) - 3'd1);
    wsh_d     = wdata_q >> {k_d, 3'b000};
    ext_lo_d  = (state_q == S_LOAD) ? mem_rd : lo_buf_q;
    ext_hi_d  = (state_q == S_LOAD_HI) ? mem_rd : hi_buf_q;
  end

  lsu_load_extract u_ext (
    .hi_buf_i (ext_hi_d),
    .lo_buf_i (ext_lo_d),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .rdata_o  (ext_d)
  );

  // Access sequencer with registered memory and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      f3_q        <= 3'b0;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      k_q         <= 2'b0;
      lo_buf_q    <= 32'b0;
      hi_buf_q    <= 32'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= WE_NONE;
      mem_a_q     <= 32'b0;
      mem_wd_q    <= 32'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            store_q     <= req_store;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            k_q         <= 2'b0;
            req_ready_q <= 1'b0;
            if (reject_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'b0;
            end else if (req_store && req_mis_d) begin
              state_q  <= S_STORE_BYTES;
              mem_we_q <= WE_B;
              mem_a_q  <= req_addr;
              mem_wd_q <= {24'b0, req_wdata[7:0]};
            end else if (req_store) begin
              state_q  <= S_STORE;
              mem_we_q <= f3_we(req_funct3);
              mem_a_q  <= req_addr;
              mem_wd_q <= req_wdata;
            end else begin
              state_q <= S_LOAD;
              mem_a_q <= req_addr;
            end
          end
        end
        S_STORE: begin
          state_q     <= S_RESP;
          mem_we_q    <= WE_NONE;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 32'b0;
        end
        S_STORE_BYTES: begin
          if (last_d) begin
            state_q     <= S_RESP;
            mem_we_q    <= WE_NONE;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'b0;
          end else begin
            k_q      <= k_d;
            mem_a_q  <= addr_q + {30'b0, k_d};
            mem_wd_q <= {24'b0, wsh_d[7:0]};
          end
        end
        S_LOAD: begin
          lo_buf_q <= mem_rd;
          if (ld_split(addr_q[1:0], f3_q)) begin
            state_q <= S_LOAD_HI;
            mem_a_q <= {addr_q[31:2], 2'b00} + 32'd4;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ext_d;
          end
        end
        S_LOAD_HI: begin
          hi_buf_q    <= mem_rd;
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ext_d;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-array memory model.
// Expected values are hand-computed from the preload pattern.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:255];
  int          wr_n;
  logic [1:0]  wl_we [0:15];
  logic [31:0] wl_a  [0:15];
  logic [31:0] wl_d  [0:15];
  logic [31:0] ra    [0:31];
  int          r_lat;
  logic [31:0] r_data;
  logic        r_err;

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = {mem[{mem_a[7:2], 2'd3}], mem[{mem_a[7:2], 2'd2}],
                   mem[{mem_a[7:2], 2'd1}], mem[{mem_a[7:2], 2'd0}]};

  always @(posedge clk) begin
    if (!reset && mem_we != 2'b00) begin
      if (wr_n < 16) begin
        wl_we[wr_n] = mem_we;
        wl_a[wr_n]  = mem_a;
        wl_d[wr_n]  = mem_wd;
      end
      wr_n = wr_n + 1;
      case (mem_we)
        2'b01: begin
          mem[{mem_a[7:2], 2'd0}] = mem_wd[7:0];
          mem[{mem_a[7:2], 2'd1}] = mem_wd[15:8];
          mem[{mem_a[7:2], 2'd2}] = mem_wd[23:16];
          mem[{mem_a[7:2], 2'd3}] = mem_wd[31:24];
        end
        2'b10: begin
          mem[mem_a[7:0]]         = mem_wd[7:0];
          mem[mem_a[7:0] + 8'd1]  = mem_wd[15:8];
        end
        default: mem[mem_a[7:0]] = mem_wd[7:0];
      endcase
    end
  end

  function automatic logic [31:0] word_at(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22;
    mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h14] = 8'h55; mem[8'h15] = 8'h66;
    mem[8'h16] = 8'h77; mem[8'h17] = 8'h88;
  endtask

  // One request; latency counts from the accept cycle as cycle 0.
  task automatic do_req(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int lat;
    @(negedge clk);
    wr_n       = 0;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      ra[lat] = mem_a;
      @(negedge clk);
      lat++;
    end
    r_lat  = lat;
    r_data = rsp_rdata;
    r_err  = rsp_err;
  endtask

  initial begin
    logic [31:0] ea [0:3];
    logic [31:0] ed [0:3];
    ea = '{32'h11, 32'h12, 32'h13, 32'h14};
    ed = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    reset = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'b0;
    req_addr = 32'b0;
    req_wdata = 32'b0;
    rsp_ready = 1'b1;
    wr_n = 0;
    load_mem();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    reset = 1'b0;

    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw10_lat", r_lat, 2);
    chk("lw10_data", r_data, 32'h44332211);
    chk("lw10_err", r_err, 0);
    chk("lw10_nowr", wr_n, 0);

    do_req(1'b0, 3'b000, 32'h17, 32'h0);
    chk("lb17_data", r_data, 32'hFFFFFF88);
    do_req(1'b0, 3'b100, 32'h17, 32'h0);
    chk("lbu17_data", r_data, 32'h00000088);
    do_req(1'b0, 3'b001, 32'h11, 32'h0);
    chk("lh11_data", r_data, 32'h00003322);
    chk("lh11_lat", r_lat, 2);

    do_req(1'b0, 3'b010, 32'h13, 32'h0);
    chk("lw13_data", r_data, 32'h77665544);
    chk("lw13_lat", r_lat, 3);
    chk("lw13_rd0", ra[1], 32'h13);
    chk("lw13_rd1", ra[2], 32'h14);

    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    chk("ill_ld_err", r_err, 1);
    chk("ill_ld_data", r_data, 0);
    chk("ill_ld_nowr", wr_n, 0);
    do_req(1'b1, 3'b100, 32'h10, 32'h12345678);
    chk("ill_st_err", r_err, 1);
    chk("ill_st_nowr", wr_n, 0);

    do_req(1'b1, 3'b010, 32'h11, 32'hDEADBEEF);
    chk("sw11_lat", r_lat, 5);
    chk("sw11_nwr", wr_n, 4);
    chk("sw11_err", r_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw11_we%0d", i), wl_we[i], 2'b11);
      chk($sformatf("sw11_a%0d", i), wl_a[i], ea[i]);
      chk($sformatf("sw11_d%0d", i), {24'b0, wl_d[i][7:0]}, ed[i]);
    end
    chk("sw11_m10", word_at(16), 32'hADBEEF11);
    chk("sw11_m14", word_at(20), 32'h887766DE);

    load_mem();
    do_req(1'b1, 3'b001, 32'h12, 32'h0000CAFE);
    chk("sh12_lat", r_lat, 2);
    chk("sh12_nwr", wr_n, 1);
    chk("sh12_we", wl_we[0], 2'b10);
    chk("sh12_a", wl_a[0], 32'h12);
    chk("sh12_m10", word_at(16), 32'hCAFE2211);

    load_mem();
    do_req(1'b1, 3'b001, 32'h13, 32'h0000CAFE);
    chk("sh13_lat", r_lat, 3);
    chk("sh13_nwr", wr_n, 2);
    chk("sh13_m10", word_at(16), 32'hFE332211);
    chk("sh13_m14", word_at(20), 32'h887766CA);

    load_mem();
    @(negedge clk);
    wr_n = 0;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h11;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abt_b0_a", mem_a, 32'h11);
    @(negedge clk);
    chk("abt_b1_we", mem_we, 2'b11);
    chk("abt_b1_a", mem_a, 32'h12);
    reset = 1'b1;
    #1;
    chk("abt_we_now", mem_we, 2'b00);
    chk("abt_rdy_now", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abt_no_rsp", rsp_valid, 0);
    end
    chk("abt_rdy", req_ready, 1);
    chk("abt_nwr", wr_n, 1);
    chk("abt_m10", word_at(16), 32'h4433EF11);
    chk("abt_m14", word_at(20), 32'h88776655);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator that drives the data-memory port on behalf of the core. Accepts one load/store request at a time over a valid/ready handshake and sequences the memory accesses. Aligned accesses use a single word/half/byte access. When enabled, misaligned accesses are split: a load is served by two word reads, a store by a series of byte writes. Loads are sign- or zero-extended and returned over a valid/ready response channel.

Parameters:
ENABLE_MISALIGNED, 1, 1 = split misaligned accesses; 0 = reject them with rsp_err and make no memory access.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  illegal funct3, or misaligned access with ENABLE_MISALIGNED=0
mem_we  out  2  00 none, 01 word, 10 half, 11 byte
mem_a  out  32  memory byte address
mem_wd  out  32  write data; half/byte write data is carried in the low bits
mem_rd  in  32  combinational read word at mem_a[31:2]

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=00, mem_a=0, mem_wd=0, state=IDLE.
- mem_we is 00 in every state except STORE and STORE_BYTES.
- Request is accepted on the cycle where req_valid && req_ready. The block latches store flag, funct3, address and data, and starts the access on the next cycle.
- Size: funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes.
- Legal funct3 values: loads 000/001/010/100/101; stores 000/001/010. Any other value goes directly to RESP with rsp_err=1 and makes no memory access.
- Misaligned definitions:
  - Store: half with a[0]=1, or word with a[1:0]≠00.
  - Load: split only when offset+size>4. A half at offset 01 is extracted from one word read.
- States:
  - IDLE: waits for an accepted request.
  - STORE: one cycle. mem_we=01/10/11, mem_a=addr, mem_wd=wdata. Next state RESP.
  - STORE_BYTES: byte counter k runs 0..size-1. mem_we=11, mem_a=addr+k, mem_wd[7:0]=wdata byte k. After the last byte, next state RESP.
  - LOAD: one cycle. mem_a=addr. mem_rd is captured into lo_buf at the clock edge. Goes to LOAD_HI if the load is split, otherwise RESP.
  - LOAD_HI: mem_a={addr[31:2],2'b00}+4, wrapping mod 2^32. mem_rd is captured into hi_buf. Next state RESP.
  - RESP: rsp_valid=1; outputs are held stable until rsp_ready. On the rsp_ready cycle the block returns to IDLE, and req_ready rises on the following cycle.
- Load extraction: the 64-bit value {hi_buf,lo_buf} is shifted right by 8*addr[1:0], then the low size bytes are taken. LB/LH sign-extend; LBU/LHU/LW zero-extend.
- Latency from the accept cycle (cycle 0) to rsp_valid:
  - aligned load or aligned store: cycle 2
  - split load: cycle 3
  - misaligned SH: cycle 3
  - misaligned SW: cycle 5
- Reset during any state forces IDLE and mem_we=00 immediately, since reset is asynchronous. Bytes already written stay written and no response is issued.
- req_valid outside IDLE is ignored; req_ready=0 in those states.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - mem_we encodings (WE_NONE=00, WE_W=01, WE_H=10, WE_B=11)
  - state enum
- Sub-module lsu_load_extract is combinational. Inputs: hi_buf, lo_buf, addr[1:0], funct3. Output: rsp_rdata.

Test Plan:
All scenarios preload mem[0x10]=0x44332211 and mem[0x14]=0x88776655, and hold rsp_ready=1.
- LW 0x10 → rsp_valid at cycle 2, rsp_rdata=0x44332211, mem_we=00 throughout.
- LB 0x17 → 0xFFFFFF88; LBU 0x17 → 0x00000088; LH 0x11 → 0x00003322 (single read).
- LW 0x13 → reads at mem_a 0x13 then 0x14, rsp_rdata=0x77665544 at cycle 3.
- SW 0x11 data 0xDEADBEEF → four byte writes:
  - mem_we=11 at a=0x11..0x14
  - wd[7:0] = EF, BE, AD, DE
  - result: mem[0x10]=0xADBEEF11, mem[0x14]=0x887766DE
  - rsp at cycle 5
- SH 0x12 data 0x0000CAFE → one write, we=10, a=0x12 → mem[0x10]=0xCAFE2211.
- Illegal and aborted requests:
  - funct3=011 load → rsp_err=1, rsp_rdata=0, no memory access.
  - Reset pulsed during the 2nd byte of the SW 0x11 case → mem_we=00 the same cycle, only 0x11 is written, no rsp, req_ready=1 after reset.
